aoi_gate_bank: RTL and testbench

AOI_GATE_BANK -- requirements
Module: aoi_gate_bank

---
 rtl/aoi_gate_bank.sv | 93 +++++++++
 tb/tb_aoi_gate_bank.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/aoi_gate_bank.sv
// Bank of AND-OR(-INVERT) gates with a pipelined propagation delay and a
// per-channel persistence filter that suppresses pulses shorter than FILTER+1 cycles.
module aoi_gate_bank #(
    parameter int CHANNELS = 2,
    parameter int GROUPS   = 2,
    parameter int WIDTH    = 2,
    parameter int DELAY    = 1,
    parameter int FILTER   = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [CHANNELS*GROUPS*WIDTH-1:0]   in,
    input  logic [CHANNELS*GROUPS-1:0]         group_en,
    input  logic [CHANNELS-1:0]                expander,
    input  logic                               invert,
    input  logic                               hold,
    output logic [CHANNELS-1:0]                y,
    output logic [CHANNELS-1:0]                y_change
);

    localparam int CW = (FILTER < 1) ? 1 : $clog2(FILTER + 1);
    localparam logic [CW-1:0] FILTER_MAX = CW'(FILTER);

    logic [CHANNELS*GROUPS-1:0] term;
    logic [CHANNELS-1:0]        raw;

    logic [CHANNELS-1:0] pipe_q [DELAY];
    logic [CHANNELS-1:0] pipe_d [DELAY];
    logic [CHANNELS-1:0] p;

    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0] y_q;
    logic [CHANNELS-1:0] y_d;
    logic [CHANNELS-1:0] chg_q;
    logic [CHANNELS-1:0] chg_d;

    genvar gi, gj;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            for (gj = 0; gj < GROUPS; gj++) begin : g_group
                assign term[gi*GROUPS+gj] = group_en[gi*GROUPS+gj]
                                          & (&in[(gi*GROUPS+gj)*WIDTH +: WIDTH]);
            end
            assign raw[gi] = ((|term[gi*GROUPS +: GROUPS]) | expander[gi]) ^ invert;
        end

        for (gi = 0; gi < DELAY; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign pipe_d[gi] = raw;
            end else begin : g_rest
                assign pipe_d[gi] = pipe_q[gi-1];
            end
        end
    endgenerate

    assign p = pipe_q[DELAY-1];

    // A mismatch must survive FILTER+1 consecutive edges; any match or hold restarts the count.
    always_comb begin
        y_d   = y_q;
        chg_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c] = '0;
            if (!hold && (p[c] != y_q[c])) begin
                if (cnt_q[c] == FILTER_MAX) begin
                    y_d[c]   = p[c];
                    chg_d[c] = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DELAY; i++) pipe_q[i] <= '1;
            for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
            y_q   <= '1;
            chg_q <= '0;
        end else begin
            for (int i = 0; i < DELAY; i++) pipe_q[i] <= pipe_d[i];
            for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_d[c];
            y_q   <= y_d;
            chg_q <= chg_d;
        end
    end

    assign y        = y_q;
    assign y_change = chg_q;

endmodule

// File: tb/tb_aoi_gate_bank.sv
// Self-checking bench for aoi_gate_bank: directed vector table, hand-written
// reset/pending sequence, and randomized traffic against a window-based reference model.
module tb_aoi_gate_bank;

    localparam int CH = 2;
    localparam int G  = 2;
    localparam int W  = 2;
    localparam int D  = 1;
    localparam int F  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          invert;
    logic          hold;
    logic [7:0]    in_v;
    logic [3:0]    en;
    logic [1:0]    expd;
    logic [1:0]    y;
    logic [1:0]    y_change;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aoi_gate_bank #(
        .CHANNELS(CH), .GROUPS(G), .WIDTH(W), .DELAY(D), .FILTER(F)
    ) dut (
        .clk(clk), .reset(reset), .in(in_v), .group_en(en),
        .expander(expd), .invert(invert), .hold(hold),
        .y(y), .y_change(y_change)
    );

    // Reference model: y[c] flips when the last FILTER+1 edges all saw an
    // un-held delayed value differing from y[c].
    typedef struct { logic [1:0] p; bit h; } rec_t;
    logic [1:0] y_m;
    logic [1:0] chg_m;
    logic [1:0] rawq [$];
    rec_t       hist [$];

    function automatic logic [1:0] model_raw();
        logic [1:0] r;
        for (int c = 0; c < CH; c++) begin
            bit s;
            s = expd[c];
            for (int g = 0; g < G; g++) begin
                bit a;
                a = en[c*G+g];
                for (int k = 0; k < W; k++) a = a & in_v[c*G*W + g*W + k];
                s = s | a;
            end
            r[c] = s ^ invert;
        end
        return r;
    endfunction

    task automatic model_step();
        rec_t r;
        bit   all;
        if (reset) begin
            y_m   = 2'b11;
            chg_m = 2'b00;
            rawq.delete();
            for (int i = 0; i < D; i++) rawq.push_back(2'b11);
            hist.delete();
        end else begin
            r.p = rawq.pop_front();
            r.h = hold;
            rawq.push_back(model_raw());
            hist.push_back(r);
            if (hist.size() > F + 1) void'(hist.pop_front());
            chg_m = 2'b00;
            for (int c = 0; c < CH; c++) begin
                all = (hist.size() == F + 1);
                foreach (hist[i]) if (hist[i].h || hist[i].p[c] == y_m[c]) all = 0;
                if (all) begin
                    y_m[c]   = r.p[c];
                    chg_m[c] = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit r, input bit inv, input bit h,
                          input logic [3:0] e, input logic [7:0] i, input logic [1:0] x);
        reset = r; invert = inv; hold = h; en = e; in_v = i; expd = x;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_y", y, y_m);
        check("model_chg", y_change, chg_m);
    endtask

    task automatic tick_expect(input string tag, input logic [1:0] ey, input logic [1:0] ec);
        tick();
        check({tag, "_y"}, y, ey);
        check({tag, "_chg"}, y_change, ec);
        $display("%s: y=%b y_change=%b", tag, y, y_change);
    endtask

    typedef struct {
        bit rst; bit inv; bit hld;
        logic [3:0] e; logic [7:0] i; logic [1:0] x;
        logic [1:0] ey; logic [1:0] ec;
        string tag;
    } vec_t;
    vec_t vecs [$];

    function automatic void add(input bit rst, input bit inv, input bit hld,
                                input logic [3:0] e, input logic [7:0] i, input logic [1:0] x,
                                input logic [1:0] ey, input logic [1:0] ec, input string tag);
        vec_t v;
        v.rst = rst; v.inv = inv; v.hld = hld; v.e = e; v.i = i; v.x = x;
        v.ey = ey; v.ec = ec; v.tag = tag;
        vecs.push_back(v);
    endfunction

    initial begin
        set_in(1, 0, 0, 4'hF, 8'h00, 2'b00);

        // Release from reset with invert=0, inputs 0: y falls on the 4th edge.
        add(1,0,0,4'hF,8'h00,2'b00, 2'b11,2'b00,"rst_state");
        add(0,0,0,4'hF,8'h00,2'b00, 2'b11,2'b00,"fall_e1");
        add(0,0,0,4'hF,8'h00,2'b00, 2'b11,2'b00,"fall_e2");
        add(0,0,0,4'hF,8'h00,2'b00, 2'b11,2'b00,"fall_e3");
        add(0,0,0,4'hF,8'h00,2'b00, 2'b00,2'b11,"fall_e4");
        add(0,0,0,4'hF,8'h00,2'b00, 2'b00,2'b00,"fall_e5");
        // AOI idle: y stays high, no pulses.
        add(1,1,0,4'hF,8'h00,2'b00, 2'b11,2'b00,"aoi_rst");
        for (int k = 0; k < 4; k++) add(0,1,0,4'hF,8'h00,2'b00, 2'b11,2'b00,"aoi_idle");
        // Channel 0 group 0 all ones.
        for (int k = 0; k < 3; k++) add(0,1,0,4'hF,8'h03,2'b00, 2'b11,2'b00,"g0_wait");
        add(0,1,0,4'hF,8'h03,2'b00, 2'b10,2'b01,"g0_fall");
        add(0,1,0,4'hF,8'h03,2'b00, 2'b10,2'b00,"g0_after");
        for (int k = 0; k < 3; k++) add(0,1,0,4'hF,8'h00,2'b00, 2'b10,2'b00,"g0off_wait");
        add(0,1,0,4'hF,8'h00,2'b00, 2'b11,2'b01,"g0off_rise");
        add(0,1,0,4'hF,8'h00,2'b00, 2'b11,2'b00,"g0off_after");
        // 2-cycle expander pulse is filtered out.
        for (int k = 0; k < 2; k++) add(0,1,0,4'hF,8'h00,2'b10, 2'b11,2'b00,"p2_on");
        for (int k = 0; k < 4; k++) add(0,1,0,4'hF,8'h00,2'b00, 2'b11,2'b00,"p2_off");
        // 3-cycle expander pulse passes, low for 3 cycles.
        for (int k = 0; k < 3; k++) add(0,1,0,4'hF,8'h00,2'b10, 2'b11,2'b00,"p3_on");
        add(0,1,0,4'hF,8'h00,2'b00, 2'b01,2'b10,"p3_fall");
        add(0,1,0,4'hF,8'h00,2'b00, 2'b01,2'b00,"p3_low2");
        add(0,1,0,4'hF,8'h00,2'b00, 2'b01,2'b00,"p3_low3");
        add(0,1,0,4'hF,8'h00,2'b00, 2'b11,2'b10,"p3_rise");
        add(0,1,0,4'hF,8'h00,2'b00, 2'b11,2'b00,"p3_after");
        // Groups disabled, then expander on channel 0.
        for (int k = 0; k < 2; k++) add(0,1,0,4'h0,8'hFF,2'b00, 2'b11,2'b00,"en0_idle");
        for (int k = 0; k < 3; k++) add(0,1,0,4'h0,8'hFF,2'b01, 2'b11,2'b00,"en0_wait");
        add(0,1,0,4'h0,8'hFF,2'b01, 2'b10,2'b01,"en0_fall");
        add(0,1,0,4'h0,8'hFF,2'b01, 2'b10,2'b00,"en0_after");
        // Hold freezes y while raw flips; update 3 edges after release.
        for (int k = 0; k < 6; k++) add(0,1,1,4'h0,8'hFF,2'b00, 2'b10,2'b00,"hold_on");
        add(0,1,0,4'h0,8'hFF,2'b00, 2'b10,2'b00,"hold_rel1");
        add(0,1,0,4'h0,8'hFF,2'b00, 2'b10,2'b00,"hold_rel2");
        add(0,1,0,4'h0,8'hFF,2'b00, 2'b11,2'b01,"hold_rel3");
        add(0,1,0,4'h0,8'hFF,2'b00, 2'b11,2'b00,"hold_rel4");

        foreach (vecs[n]) begin
            set_in(vecs[n].rst, vecs[n].inv, vecs[n].hld, vecs[n].e, vecs[n].i, vecs[n].x);
            tick_expect(vecs[n].tag, vecs[n].ey, vecs[n].ec);
        end

        // Reset arriving mid-count wipes the pending update.
        set_in(0, 1, 0, 4'h0, 8'hFF, 2'b01);
        tick_expect("pend_e1", 2'b11, 2'b00);
        tick_expect("pend_e2", 2'b11, 2'b00);
        set_in(1, 1, 0, 4'h0, 8'hFF, 2'b01);
        tick_expect("pend_rst", 2'b11, 2'b00);
        set_in(0, 1, 0, 4'h0, 8'hFF, 2'b01);
        tick_expect("pend_r1", 2'b11, 2'b00);
        tick_expect("pend_r2", 2'b11, 2'b00);
        tick_expect("pend_r3", 2'b11, 2'b00);
        tick_expect("pend_r4", 2'b10, 2'b01);

        // Randomized traffic; inputs held for a few cycles so some changes pass the filter.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 3) == 0) invert = ~invert;
                en   = 4'($urandom);
                in_v = 8'($urandom | $urandom);
                expd = 2'($urandom & $urandom);
            end
            tick();
            if (n % 50 == 0)
                $display("rand %0d: y=%b y_change=%b model=%b/%b", n, y, y_change, y_m, chg_m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
